// File: rtl/async_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_if
// Purpose  : Producer/consumer handshake bundle for the single-clock FIFO.
//            The master side drives requests and write data; the slave side
//            (the FIFO) returns the head word and the flow-control flags.
// Revision : 1.0 - initial release
// ============================================================================
interface async_fifo_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
);
    // Write side
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             awfull;

    // Read side
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             arempty;

    // Producer/consumer view
    modport master (
        output winc,
        output wdata,
        output rinc,
        input  wfull,
        input  awfull,
        input  rdata,
        input  rempty,
        input  arempty
    );

    // FIFO view
    modport slave (
        input  winc,
        input  wdata,
        input  rinc,
        output wfull,
        output awfull,
        output rdata,
        output rempty,
        output arempty
    );
endinterface
`default_nettype wire

// File: rtl/async_fifo.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo
// Purpose  : Single-clock FIFO of 2**ASIZE words of DSIZE bits with a
//            show-ahead read port and full / almost-full / empty /
//            almost-empty flags. Pointers carry one extra wrap bit so full
//            and empty are distinguishable when the index bits match.
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    async_fifo_if.slave fifo
);
    localparam int DEPTH = 1 << ASIZE;

    // Pointer difference that means "one slot left" (DEPTH-1) and "one word"
    localparam logic [ASIZE:0] PTR_ONE     = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] AFULL_COUNT = {1'b0, {ASIZE{1'b1}}};

    // Storage; contents are intentionally not reset
    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0] wptr_q;
    logic [ASIZE:0] wptr_d;
    logic [ASIZE:0] rptr_q;
    logic [ASIZE:0] rptr_d;
    logic [ASIZE:0] count;

    logic           wr_accept;
    logic           rd_accept;
    logic           empty;
    logic           full;

    // Flags come straight from the registered pointers, so they reflect an
    // accepted write/read in the cycle following the edge
    always_comb begin
        count   = wptr_q - rptr_q;
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                  (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
        // Accept decisions use the pre-edge flags: a full FIFO still pops,
        // an empty FIFO still pushes, so simultaneous requests never deadlock
        wr_accept = fifo.winc && !full;
        rd_accept = fifo.rinc && !empty;
    end

    // Next-state pointers; modulo 2**(ASIZE+1) wrap falls out of the width
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_accept) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset discards everything and overrides requests
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Memory write; gated by reset so a write request during reset is lost
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wptr_q[ASIZE-1:0]] <= fifo.wdata;
        end
    end

    // Show-ahead head word and flag outputs
    always_comb begin
        fifo.rdata   = mem_q[rptr_q[ASIZE-1:0]];
        fifo.rempty  = empty;
        fifo.wfull   = full;
        fifo.awfull  = (count == AFULL_COUNT);
        fifo.arempty = (count == PTR_ONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo
// Purpose  : Directed self-checking bench for async_fifo (32 x 16 default).
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo;
    localparam int DSIZE = 32;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [$];

    async_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of traffic against a queue model (used for the wrap rounds)
    task automatic cycle(input logic w, input logic [31:0] d, input logic r);
        logic do_w;
        logic do_r;
        do_r = r && (model.size() != 0);
        do_w = w && (model.size() != DEPTH);
        bus.winc  = w;
        bus.wdata = d;
        bus.rinc  = r;
        if (do_r) chk("wrap_rdata", bus.rdata, model[0]);
        tick();
        if (do_r) void'(model.pop_front());
        if (do_w) model.push_back(d);
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        chk("wrap_rempty", {31'b0, bus.rempty}, {31'b0, model.size() == 0});
        chk("wrap_wfull",  {31'b0, bus.wfull},  {31'b0, model.size() == DEPTH});
    endtask

    initial begin
        rst       = 1'b1;
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // IDLE
        for (int i = 0; i < 10; i++) tick();
        chk("idle_wfull",   {31'b0, bus.wfull},   32'd0);
        chk("idle_rempty",  {31'b0, bus.rempty},  32'd1);
        chk("idle_awfull",  {31'b0, bus.awfull},  32'd0);
        chk("idle_arempty", {31'b0, bus.arempty}, 32'd0);

        // Read while empty is ignored
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        chk("empty_rd_rempty",  {31'b0, bus.rempty},  32'd1);
        chk("empty_rd_arempty", {31'b0, bus.arempty}, 32'd0);

        // SIMPLE
        bus.winc = 1'b1; bus.wdata = 32'hA;
        tick();
        bus.winc = 1'b0;
        chk("simple_rempty",  {31'b0, bus.rempty},  32'd0);
        chk("simple_arempty", {31'b0, bus.arempty}, 32'd1);
        chk("simple_rdata",   bus.rdata,            32'hA);
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        chk("simple_pop_rempty", {31'b0, bus.rempty}, 32'd1);

        // MULTI
        for (int i = 0; i < 10; i++) begin
            bus.winc = 1'b1; bus.wdata = i;
            tick();
        end
        bus.winc = 1'b0;
        chk("multi_arempty", {31'b0, bus.arempty}, 32'd0);
        bus.rinc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("multi_rdata", bus.rdata, i);
            tick();
        end
        bus.rinc = 1'b0;
        chk("multi_rempty", {31'b0, bus.rempty}, 32'd1);

        // FULL
        for (int i = 0; i < 16; i++) begin
            bus.winc = 1'b1; bus.wdata = i;
            tick();
            if (i == 14) begin
                chk("full15_awfull", {31'b0, bus.awfull}, 32'd1);
                chk("full15_wfull",  {31'b0, bus.wfull},  32'd0);
            end
        end
        chk("full16_wfull",  {31'b0, bus.wfull},  32'd1);
        chk("full16_awfull", {31'b0, bus.awfull}, 32'd0);
        bus.wdata = 32'd99;
        tick();
        bus.winc = 1'b0;
        chk("full_drop_wfull", {31'b0, bus.wfull}, 32'd1);
        bus.rinc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("full_drain_rdata", bus.rdata, i);
            tick();
        end
        bus.rinc = 1'b0;
        chk("full_drain_rempty", {31'b0, bus.rempty}, 32'd1);

        // Full with simultaneous read+write: only the read proceeds
        for (int i = 0; i < 16; i++) begin
            bus.winc = 1'b1; bus.wdata = 32'h100 + i;
            tick();
        end
        bus.wdata = 32'd77;
        bus.rinc  = 1'b1;
        chk("full_rw_rdata", bus.rdata, 32'h100);
        tick();
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        chk("full_rw_wfull",  {31'b0, bus.wfull},  32'd0);
        chk("full_rw_awfull", {31'b0, bus.awfull}, 32'd1);
        bus.rinc = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("full_rw_drain", bus.rdata, 32'h100 + i);
            tick();
        end
        bus.rinc = 1'b0;
        chk("full_rw_rempty", {31'b0, bus.rempty}, 32'd1);

        // EMPTY/WRAP: three rounds of 16 in / 16 out with overlap phases
        for (int r = 0; r < 3; r++) begin
            cycle(1'b1, 32'h1000 * (r + 1), 1'b1);
            chk("wrap_first_arempty", {31'b0, bus.arempty}, 32'd1);
            for (int k = 1; k < 8; k++)  cycle(1'b1, 32'h1000 * (r + 1) + k, 1'b0);
            for (int k = 8; k < 16; k++) cycle(1'b1, 32'h1000 * (r + 1) + k, 1'b1);
            for (int k = 0; k < 9; k++)  cycle(1'b0, 32'h0, 1'b1);
        end

        // RESET mid-operation, with a write request held during reset
        for (int i = 0; i < 5; i++) begin
            bus.winc = 1'b1; bus.wdata = 32'h10 + i;
            tick();
        end
        rst       = 1'b1;
        bus.wdata = 32'hEE;
        tick();
        rst      = 1'b0;
        bus.winc = 1'b0;
        chk("rst_rempty",  {31'b0, bus.rempty},  32'd1);
        chk("rst_wfull",   {31'b0, bus.wfull},   32'd0);
        chk("rst_arempty", {31'b0, bus.arempty}, 32'd0);
        bus.winc = 1'b1; bus.wdata = 32'h5A;
        tick();
        bus.winc = 1'b0;
        chk("rst_after_rdata",   bus.rdata,            32'h5A);
        chk("rst_after_arempty", {31'b0, bus.arempty}, 32'd1);
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        chk("rst_after_rempty", {31'b0, bus.rempty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
